// File: rtl/brick_move_ctrl.sv
// Move initiator for three brick piles: checks legality, then pulses moins on src and plus on dst.
// Optional build macro MOVE_COUNT_EN adds the saturating nb_moves_o counter of completed moves.
module brick_move_ctrl #(
    parameter int unsigned W    = 3,
    parameter int unsigned HMAX = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_i,
    input  logic [1:0]   src_i,
    input  logic [1:0]   dst_i,
    input  logic [W-1:0] h0_i,
    input  logic [W-1:0] h1_i,
    input  logic [W-1:0] h2_i,
    output logic [2:0]   plus_o,
    output logic [2:0]   moins_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [1:0]   err_code_o
`ifdef MOVE_COUNT_EN
    ,
    output logic [7:0]   nb_moves_o
`endif
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCheck = 3'd1;
    localparam logic [2:0] StTake  = 3'd2;
    localparam logic [2:0] StPut   = 3'd3;
    localparam logic [2:0] StFin   = 3'd4;

    localparam logic [1:0] ErrNone  = 2'b00;
    localparam logic [1:0] ErrIndex = 2'b01;
    localparam logic [1:0] ErrEmpty = 2'b10;
    localparam logic [1:0] ErrFull  = 2'b11;

    localparam logic [W-1:0] HMaxW = W'(HMAX);

    logic [2:0]   state_q, state_d;
    logic [1:0]   src_q, src_d;
    logic [1:0]   dst_q, dst_d;
    logic [1:0]   fault_q, fault_d;
    logic [2:0]   plus_q, plus_d;
    logic [2:0]   moins_q, moins_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [1:0]   err_code_q, err_code_d;

    logic [W-1:0] h_src;
    logic [W-1:0] h_dst;
    logic [1:0]   fault;

    // Height lookup through the latched indices; index 3 is rejected before it matters.
    always_comb begin
        h_src = h0_i;
        unique case (src_q)
            2'd1:    h_src = h1_i;
            2'd2:    h_src = h2_i;
            default: h_src = h0_i;
        endcase
    end

    always_comb begin
        h_dst = h0_i;
        unique case (dst_q)
            2'd1:    h_dst = h1_i;
            2'd2:    h_dst = h2_i;
            default: h_dst = h0_i;
        endcase
    end

    always_comb begin
        fault = ErrNone;
        if (src_q == 2'd3 || dst_q == 2'd3 || src_q == dst_q) begin
            fault = ErrIndex;
        end else if (h_src == '0) begin
            fault = ErrEmpty;
        end else if (h_dst >= HMaxW) begin
            fault = ErrFull;
        end
    end

    // A rejected move goes CHECK -> FIN so err lands on the same cycle slot as moins would.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        fault_d    = fault_q;
        plus_d     = 3'b000;
        moins_d    = 3'b000;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    src_d   = src_i;
                    dst_d   = dst_i;
                    busy_d  = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                fault_d = fault;
                state_d = (fault == ErrNone) ? StTake : StFin;
            end
            StTake: begin
                moins_d = 3'b001 << src_q;
                state_d = StPut;
            end
            StPut: begin
                plus_d  = 3'b001 << dst_q;
                state_d = StFin;
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
                if (fault_q == ErrNone) begin
                    done_d     = 1'b1;
                    err_code_d = ErrNone;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = fault_q;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            src_q      <= 2'd0;
            dst_q      <= 2'd0;
            fault_q    <= ErrNone;
            plus_q     <= 3'b000;
            moins_q    <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            fault_q    <= fault_d;
            plus_q     <= plus_d;
            moins_q    <= moins_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign plus_o     = plus_q;
    assign moins_o    = moins_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

`ifdef MOVE_COUNT_EN
    logic [7:0] nb_moves_q, nb_moves_d;

    always_comb begin
        nb_moves_d = nb_moves_q;
        if (done_d && nb_moves_q != 8'hFF) begin
            nb_moves_d = nb_moves_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nb_moves_q <= 8'd0;
        end else begin
            nb_moves_q <= nb_moves_d;
        end
    end

    assign nb_moves_o = nb_moves_q;
`endif

endmodule

// File: tb/tb_brick_move_ctrl.sv
// Self-checking bench for brick_move_ctrl: timeline model checked every cycle plus directed literals.
// Build with MOVE_COUNT_EN defined to also exercise the move counter.
module tb_brick_move_ctrl;

    localparam int unsigned W    = 3;
    localparam int unsigned HMAX = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic [1:0]   src, dst;
    logic [W-1:0] h0, h1, h2;
    logic [2:0]   plus_o, moins_o;
    logic         busy_o, done_o, err_o;
    logic [1:0]   err_code_o;
`ifdef MOVE_COUNT_EN
    logic [7:0]   nb_moves_o;
`endif

    brick_move_ctrl #(.W(W), .HMAX(HMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .src_i      (src),
        .dst_i      (dst),
        .h0_i       (h0),
        .h1_i       (h1),
        .h2_i       (h2),
        .plus_o     (plus_o),
        .moins_o    (moins_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
`ifdef MOVE_COUNT_EN
        ,
        .nb_moves_o (nb_moves_o)
`endif
    );

    always #5 clk = ~clk;

    // Piles: fixed values f[] from stimulus, or live counters p[] driven by the DUT pulses.
    logic [W-1:0] f [3];
    logic [W-1:0] p [3];
    logic         live;
    assign h0 = live ? p[0] : f[0];
    assign h1 = live ? p[1] : f[1];
    assign h2 = live ? p[2] : f[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] legality(input logic [1:0] s, input logic [1:0] d,
                                            input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c);
        logic [W-1:0] hh [3];
        hh[0] = a; hh[1] = b; hh[2] = c;
        if (s > 2 || d > 2 || s == d) return 2'b01;
        if (hh[s] == 0) return 2'b10;
        if (int'(hh[d]) >= int'(HMAX)) return 2'b11;
        return 2'b00;
    endfunction

    // Model: a move accepted at edge A produces its effects at fixed offsets from A.
    int         cyc = 0;
    int         acc = -1;
    logic [1:0] ms, md, mcode;
    logic [2:0] e_plus, e_moins;
    logic       e_busy, e_done, e_err;
    logic [1:0] e_code;
    int         e_nb;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                acc = -1;
                e_plus = 0; e_moins = 0; e_busy = 0; e_done = 0; e_err = 0;
                e_code = 0; e_nb = 0;
            end else begin
                e_plus = 0; e_moins = 0; e_done = 0; e_err = 0;
                if (acc < 0) begin
                    if (req) begin
                        acc = cyc; ms = src; md = dst; e_busy = 1;
                    end
                end else begin
                    case (cyc - acc)
                        1: mcode = legality(ms, md, h0, h1, h2);
                        2: begin
                            if (mcode != 0) begin
                                e_err = 1; e_code = mcode; e_busy = 0; acc = -1;
                            end else begin
                                e_moins = 3'b001 << ms;
                            end
                        end
                        3: e_plus = 3'b001 << md;
                        4: begin
                            e_done = 1; e_busy = 0; e_code = 0; acc = -1;
                            if (e_nb < 255) e_nb++;
                        end
                        default: ;
                    endcase
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!live) p[i] <= f[i];
                else p[i] <= p[i] + {2'b00, plus_o[i]} - {2'b00, moins_o[i]};
            end
            cyc++;
        end
    end

    int n_done = 0;
    int done_at[$];

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (cyc > 0) begin
                chk("plus", 32'(plus_o), 32'(e_plus));
                chk("moins", 32'(moins_o), 32'(e_moins));
                chk("busy", 32'(busy_o), 32'(e_busy));
                chk("done", 32'(done_o), 32'(e_done));
                chk("err", 32'(err_o), 32'(e_err));
                chk("err_code", 32'(err_code_o), 32'(e_code));
                chk("plus_and_moins", 32'(plus_o & moins_o), 32'd0);
                chk("onehot", 32'($countones(plus_o) <= 1 && $countones(moins_o) <= 1), 32'd1);
`ifdef MOVE_COUNT_EN
                chk("nb_moves", 32'(nb_moves_o), 32'(e_nb));
`endif
                if (done_o === 1'b1) begin
                    n_done++;
                    done_at.push_back(cyc);
                end
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Leaves req low at the negedge after acceptance edge N.
    task automatic do_req(input logic [1:0] s, input logic [1:0] d);
        @(negedge clk);
        req = 1; src = s; dst = d;
        @(negedge clk);
        req = 0;
    endtask

    task automatic set_h(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        @(negedge clk);
        f[0] = a; f[1] = b; f[2] = c;
    endtask

    initial begin
        int d0;
        reset = 1; req = 0; src = 0; dst = 0; live = 0;
        f[0] = 0; f[1] = 0; f[2] = 0;
        edges(2);
        @(negedge clk);
        reset = 0;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_pulses", 32'({plus_o, moins_o, done_o, err_o}), 32'd0);
        chk("reset_code", 32'(err_code_o), 32'd0);

        // 1: legal move 0 -> 2
        set_h(3, 0, 0);
        do_req(0, 2);
        edges(2);
        chk("t1_moins", 32'(moins_o), 32'b001);
        chk("t1_busy", 32'(busy_o), 32'd1);
        edges(1);
        chk("t1_plus", 32'(plus_o), 32'b100);
        chk("t1_moins_off", 32'(moins_o), 32'd0);
        edges(1);
        chk("t1_done", 32'(done_o), 32'd1);
        chk("t1_busy_off", 32'(busy_o), 32'd0);
        chk("t1_code", 32'(err_code_o), 32'b00);

        // 2: empty source
        set_h(0, 2, 0);
        do_req(0, 1);
        edges(2);
        chk("t2_err", 32'(err_o), 32'd1);
        chk("t2_code", 32'(err_code_o), 32'b10);
        chk("t2_pulses", 32'({plus_o, moins_o}), 32'd0);
        edges(1);
        chk("t2_err_off", 32'(err_o), 32'd0);
        chk("t2_code_held", 32'(err_code_o), 32'b10);

        // 3: full destination, bad index, src == dst
        set_h(1, 7, 0);
        do_req(0, 1);
        edges(2);
        chk("t3_full", 32'(err_code_o), 32'b11);
        do_req(3, 1);
        edges(2);
        chk("t3_index", 32'(err_code_o), 32'b01);
        chk("t3_index_err", 32'(err_o), 32'd1);
        do_req(1, 1);
        edges(2);
        chk("t3_same", 32'(err_code_o), 32'b01);
        chk("t3_same_err", 32'(err_o), 32'd1);

        // 4: req held 12 edges with live piles: accepts at N, N+5, N+10
        set_h(5, 0, 0);
        @(negedge clk);
        live = 1;
        done_at.delete();
        d0 = n_done;
        @(negedge clk);
        req = 1; src = 0; dst = 1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        req = 0;
        edges(10);
        chk("t4_moves", 32'(n_done - d0), 32'd3);
        if (done_at.size() == 3) begin
            chk("t4_pitch1", 32'(done_at[1] - done_at[0]), 32'd5);
            chk("t4_pitch2", 32'(done_at[2] - done_at[1]), 32'd5);
        end else begin
            chk("t4_done_count", 32'(done_at.size()), 32'd3);
        end
        chk("t4_pile0", 32'(p[0]), 32'd2);
        chk("t4_pile1", 32'(p[1]), 32'd3);
        @(negedge clk);
        live = 0;

        // 5: reset during PUT
        set_h(3, 0, 0);
        do_req(0, 2);
        edges(2);
        chk("t5_moins", 32'(moins_o), 32'b001);
        d0 = n_done;
        @(negedge clk);
        reset = 1;
        edges(1);
        chk("t5_plus", 32'(plus_o), 32'd0);
        chk("t5_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        reset = 0;
        edges(4);
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        do_req(1, 0);
        edges(2);
        chk("t5_restart_err", 32'(err_code_o), 32'b10);

`ifdef MOVE_COUNT_EN
        // 6: counter counts legal moves only and saturates
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        set_h(3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do_req(0, 2);
            edges(4);
        end
        do_req(1, 1);
        edges(4);
        chk("t6_nb3", 32'(nb_moves_o), 32'd3);
        @(negedge clk);
        req = 1; src = 0; dst = 2;
        repeat (1500) @(posedge clk);
        @(negedge clk);
        req = 0;
        edges(8);
        chk("t6_nb_sat", 32'(nb_moves_o), 32'd255);
`endif

        edges(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
